// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
//
// Game-score stage that feeds the binary-to-BCD converter driving the two-digit
// seven-segment display. It counts hits, tracks lives, runs the IDLE/PLAY/OVER
// game flow and keeps a session high score. Score and high score are
// saturated at MAX_SCORE (at most 99), so the tens digit never exceeds 9.
//
// Parameters:
//   MAX_SCORE   saturation ceiling for score (1..99)
//   HIT_POINTS  points added per hit (1..MAX_SCORE)
//   START_LIVES lives loaded at game start (1..3)
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   rst_n       asynchronous, active-low reset
//   start       start/restart request (level, edge-detected internally)
//   hit         one-cycle pulse, the player scored
//   miss        one-cycle pulse, the player lost a life
//   score       current score, binary, 0..MAX_SCORE
//   high_score  best final score since reset, binary
//   lives       remaining lives
//   playing     high while in PLAY
//   game_over   high while in OVER
//   new_high    high while in OVER if the last game set a new high score
// -----------------------------------------------------------------------------
module score_keeper #(
  parameter int unsigned MAX_SCORE   = 99,
  parameter int unsigned HIT_POINTS  = 1,
  parameter int unsigned START_LIVES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  output logic [7:0] score,
  output logic [7:0] high_score,
  output logic [1:0] lives,
  output logic       playing,
  output logic       game_over,
  output logic       new_high
);

  // 9-bit views of the parameters so the hit addition cannot wrap at 8 bits.
  localparam logic [8:0] MAX_SCORE_W   = 9'(MAX_SCORE);
  localparam logic [8:0] HIT_POINTS_W  = 9'(HIT_POINTS);
  localparam logic [1:0] START_LIVES_W = 2'(START_LIVES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_OVER = 2'b10,
    ST_BAD  = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic        start_q, start_d;
  logic        armed_q, armed_d;
  logic [7:0]  score_q, score_d;
  logic [7:0]  high_q, high_d;
  logic [1:0]  lives_q, lives_d;
  logic        new_high_q, new_high_d;
  logic        playing_q, playing_d;
  logic        game_over_q, game_over_d;

  logic        start_rise;
  logic [8:0]  score_sum;
  logic [7:0]  score_sat;
  logic [7:0]  score_next;

  // Edge detect on start. armed_q stays low until start has been seen low at
  // least once after reset, so a start level held through reset release does
  // not count as a press; start_q itself still resets to 0.
  always_comb begin
    start_d    = start;
    armed_d    = armed_q | ~start;
    start_rise = start & ~start_q & armed_q;
  end

  // Saturating score update used on any PLAY cycle, including the cycle of
  // the killing miss.
  always_comb begin
    score_sum  = {1'b0, score_q} + HIT_POINTS_W;
    score_sat  = (score_sum > MAX_SCORE_W) ? MAX_SCORE_W[7:0] : score_sum[7:0];
    score_next = hit ? score_sat : score_q;
  end

  // Game flow: next state and next values of every registered output.
  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    high_d     = high_q;
    lives_d    = lives_q;
    new_high_d = new_high_q;

    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d    = ST_PLAY;
          score_d    = 8'd0;
          lives_d    = START_LIVES_W;
          new_high_d = 1'b0;
        end
      end

      ST_PLAY: begin
        score_d = score_next;
        if (miss) begin
          if (lives_q > 2'd1) begin
            lives_d = lives_q - 2'd1;
          end else begin
            // Last life gone: the high score comparison uses the score that
            // includes a hit arriving in this same cycle. A tie is not a win.
            lives_d = 2'd0;
            state_d = ST_OVER;
            if (score_next > high_q) begin
              high_d     = score_next;
              new_high_d = 1'b1;
            end else begin
              new_high_d = 1'b0;
            end
          end
        end
      end

      ST_OVER: begin
        if (start_rise) begin
          state_d    = ST_PLAY;
          score_d    = 8'd0;
          lives_d    = START_LIVES_W;
          new_high_d = 1'b0;
        end
      end

      default: begin
        // Unused encoding: fall back to IDLE with everything cleared.
        state_d    = ST_IDLE;
        score_d    = 8'd0;
        high_d     = 8'd0;
        lives_d    = 2'd0;
        new_high_d = 1'b0;
      end
    endcase

    playing_d   = (state_d == ST_PLAY);
    game_over_d = (state_d == ST_OVER);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      armed_q     <= 1'b0;
      score_q     <= 8'd0;
      high_q      <= 8'd0;
      lives_q     <= 2'd0;
      new_high_q  <= 1'b0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      armed_q     <= armed_d;
      score_q     <= score_d;
      high_q      <= high_d;
      lives_q     <= lives_d;
      new_high_q  <= new_high_d;
      playing_q   <= playing_d;
      game_over_q <= game_over_d;
    end
  end

  assign score      = score_q;
  assign high_score = high_q;
  assign lives      = lives_q;
  assign playing    = playing_q;
  assign game_over  = game_over_q;
  assign new_high   = new_high_q;

endmodule

// File: tb/tb_score_keeper.sv
// -----------------------------------------------------------------------------
// tb_score_keeper
//
// Directed bench for score_keeper. Instance dut_a uses HIT_POINTS = 1 and is
// driven from a vector table plus hand-written sequences; dut_b uses
// HIT_POINTS = 10 to exercise saturation at 99.
// -----------------------------------------------------------------------------
module tb_score_keeper;

  logic       clk;
  logic       rst_n;
  logic       start, hit, miss;
  logic [7:0] score, high_score;
  logic [1:0] lives;
  logic       playing, game_over, new_high;

  logic       start_b, hit_b, miss_b;
  logic [7:0] score_b, high_score_b;
  logic [1:0] lives_b;
  logic       playing_b, game_over_b, new_high_b;

  int n_checks;
  int n_errors;

  score_keeper #(.MAX_SCORE(99), .HIT_POINTS(1), .START_LIVES(3)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .hit        (hit),
    .miss       (miss),
    .score      (score),
    .high_score (high_score),
    .lives      (lives),
    .playing    (playing),
    .game_over  (game_over),
    .new_high   (new_high)
  );

  score_keeper #(.MAX_SCORE(99), .HIT_POINTS(10), .START_LIVES(3)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_b),
    .hit        (hit_b),
    .miss       (miss_b),
    .score      (score_b),
    .high_score (high_score_b),
    .lives      (lives_b),
    .playing    (playing_b),
    .game_over  (game_over_b),
    .new_high   (new_high_b)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       s, h, m;
    logic [7:0] e_score, e_high;
    logic [1:0] e_lives;
    logic       e_play, e_over, e_nh;
  } vec_t;

  vec_t vecs[15];

  // Drive dut_a inputs on the falling edge, then sample 1 ns after the next
  // rising edge, where the effect of those inputs must already be visible.
  task automatic applyStimulus(input logic s, input logic h, input logic m);
    @(negedge clk);
    start = s;
    hit   = h;
    miss  = m;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] e_score,
                             input logic [7:0] e_high, input logic [1:0] e_lives,
                             input logic e_play, input logic e_over, input logic e_nh);
    n_checks++;
    if ({score, high_score, lives, playing, game_over, new_high} !==
        {e_score, e_high, e_lives, e_play, e_over, e_nh}) begin
      n_errors++;
      $display("[TB] FAIL %s: got score=%0d high=%0d lives=%0d play=%0b over=%0b nh=%0b, want score=%0d high=%0d lives=%0d play=%0b over=%0b nh=%0b",
               name, score, high_score, lives, playing, game_over, new_high,
               e_score, e_high, e_lives, e_play, e_over, e_nh);
    end
  endtask

  task automatic checkB(input string name, input logic [7:0] e_score,
                        input logic [1:0] e_lives, input logic e_play);
    n_checks++;
    if ({score_b, lives_b, playing_b} !== {e_score, e_lives, e_play}) begin
      n_errors++;
      $display("[TB] FAIL %s: got score=%0d lives=%0d play=%0b, want score=%0d lives=%0d play=%0b",
               name, score_b, lives_b, playing_b, e_score, e_lives, e_play);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    //            s  h  m  score high lives play over nh
    vecs[0]  = '{1'b0,1'b0,1'b0, 8'd0, 8'd0, 2'd0, 1'b0,1'b0,1'b0}; // idle
    vecs[1]  = '{1'b0,1'b1,1'b0, 8'd0, 8'd0, 2'd0, 1'b0,1'b0,1'b0}; // hit ignored
    vecs[2]  = '{1'b1,1'b0,1'b0, 8'd0, 8'd0, 2'd3, 1'b1,1'b0,1'b0}; // start
    vecs[3]  = '{1'b1,1'b1,1'b0, 8'd1, 8'd0, 2'd3, 1'b1,1'b0,1'b0}; // held, hit
    vecs[4]  = '{1'b1,1'b1,1'b0, 8'd2, 8'd0, 2'd3, 1'b1,1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b1,1'b0, 8'd3, 8'd0, 2'd3, 1'b1,1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b1,1'b0, 8'd4, 8'd0, 2'd3, 1'b1,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b1,1'b0, 8'd5, 8'd0, 2'd3, 1'b1,1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b1,1'b0, 8'd6, 8'd0, 2'd3, 1'b1,1'b0,1'b0};
    vecs[9]  = '{1'b0,1'b1,1'b0, 8'd7, 8'd0, 2'd3, 1'b1,1'b0,1'b0};
    vecs[10] = '{1'b0,1'b0,1'b1, 8'd7, 8'd0, 2'd2, 1'b1,1'b0,1'b0}; // miss
    vecs[11] = '{1'b0,1'b0,1'b1, 8'd7, 8'd0, 2'd1, 1'b1,1'b0,1'b0};
    vecs[12] = '{1'b0,1'b0,1'b1, 8'd7, 8'd7, 2'd0, 1'b0,1'b1,1'b1}; // over
    vecs[13] = '{1'b0,1'b1,1'b0, 8'd7, 8'd7, 2'd0, 1'b0,1'b1,1'b1}; // frozen
    vecs[14] = '{1'b1,1'b0,1'b0, 8'd0, 8'd7, 2'd3, 1'b1,1'b0,1'b0}; // restart

    start = 1'b0; hit = 1'b0; miss = 1'b0;
    start_b = 1'b0; hit_b = 1'b0; miss_b = 1'b0;
    rst_n = 1'b0;
    #12;
    checkOutput("reset", 8'd0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: basic scoring, one start per press, game over, frozen OVER.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].s, vecs[i].h, vecs[i].m);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_score, vecs[i].e_high,
                  vecs[i].e_lives, vecs[i].e_play, vecs[i].e_over, vecs[i].e_nh);
    end

    // Start stays high: no further restarts clear the score. Hits at steps 3, 9.
    for (int i = 0; i < 19; i++) begin
      applyStimulus(1'b1, (i == 3) || (i == 9), 1'b0);
      checkOutput($sformatf("held%0d", i), 8'((i >= 3) + (i >= 9)), 8'd7,
                  2'd3, 1'b1, 1'b0, 1'b0);
    end
    // Lower final score: high score kept, no new high.
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("low_game", 8'd2, 8'd7, 2'd0, 1'b0, 1'b1, 1'b0);

    // Hit with killing miss counts: final 8 beats 7.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("restart2", 8'd0, 8'd7, 2'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("hit_miss", 8'd7, 8'd7, 2'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("kill_hit", 8'd8, 8'd8, 2'd0, 1'b0, 1'b1, 1'b1);

    // Same final score again: a tie is not a new high.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("restart3", 8'd0, 8'd8, 2'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("tie", 8'd8, 8'd8, 2'd0, 1'b0, 1'b1, 1'b0);

    // Mid-game asynchronous reset with score 40, lives 2.
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("pre_reset", 8'd40, 8'd8, 2'd2, 1'b1, 1'b0, 1'b0);
    #2;
    start = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 8'd0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Start held through reset release is not a press.
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("held_thru_reset", 8'd0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("press_after_reset", 8'd0, 8'd0, 2'd3, 1'b1, 1'b0, 1'b0);

    // Saturation on dut_b (10 points per hit).
    start_b = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkB("b_start", 8'd0, 2'd3, 1'b1);
    start_b = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      hit_b = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkB($sformatf("b_hit%0d", k), (k <= 9) ? 8'(10 * k) : 8'd99, 2'd3, 1'b1);
    end
    hit_b = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
